// File: rtl/dual_core_seq.sv
`default_nettype none
// ============================================================================
//  Module      : dual_core_seq
//  Description : Instruction sequencer for the two-core attention array.
//                Emits per-core 19-bit words for Q load, K load, execute,
//                drain, ofifo->pmem transfer and normalization.
//  Revision    : 1.0  initial release
// ============================================================================
module dual_core_seq #(
    parameter int COL   = 8,
    parameter int N_Q   = 8,
    parameter int DRAIN = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [1:0]  core_en_i,
    input  logic        hold_i,
    output logic [18:0] inst1_o,
    output logic [18:0] inst2_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [2:0]  phase_o
);

    localparam int CNT_W = 8;

    localparam int B_EXT_RD   = 18;
    localparam int B_DIV      = 17;
    localparam int B_ACC      = 16;
    localparam int B_SUM      = 15;
    localparam int B_OFIFO_RD = 14;
    localparam int B_QK_RD    = 13;
    localparam int B_QK_WR    = 12;
    localparam int B_PMEM_RD  = 11;
    localparam int B_PMEM_WR  = 10;
    localparam int B_EXECUTE  = 9;
    localparam int B_LOAD     = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_QLOAD = 3'd1,
        S_KLOAD = 3'd2,
        S_EXEC  = 3'd3,
        S_DRAIN = 3'd4,
        S_OFIFO = 3'd5,
        S_NORM  = 3'd6,
        S_DONE  = 3'd7
    } state_e;

    // The _q position registers describe the word currently on the outputs.
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [1:0]         sub_q,   sub_d;
    logic [1:0]         en_q,    en_d;
    logic               frozen_d;
    logic [18:0]        word_d;

    logic [18:0]        inst1_q, inst2_q;
    logic               busy_q,  done_q;
    logic [2:0]         phase_q;

    function automatic logic is_last(input logic [CNT_W-1:0] c, input int n);
        return c == CNT_W'(n - 1);
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sub_d    = sub_q;
        en_d     = en_q;
        frozen_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    en_d    = core_en_i;
                    cnt_d   = '0;
                    sub_d   = '0;
                    state_d = (core_en_i == 2'b00) ? S_DONE : S_QLOAD;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: begin
                if (hold_i) begin
                    frozen_d = 1'b1;
                end else begin
                    unique case (state_q)
                        S_QLOAD: begin
                            if (is_last(cnt_q, N_Q)) begin
                                state_d = S_KLOAD;
                                cnt_d   = '0;
                            end else begin
                                cnt_d = cnt_q + 1'b1;
                            end
                        end
                        S_KLOAD: begin
                            if (is_last(cnt_q, COL)) begin
                                state_d = S_EXEC;
                                cnt_d   = '0;
                            end else begin
                                cnt_d = cnt_q + 1'b1;
                            end
                        end
                        S_EXEC: begin
                            if (is_last(cnt_q, N_Q)) begin
                                state_d = S_DRAIN;
                                cnt_d   = '0;
                            end else begin
                                cnt_d = cnt_q + 1'b1;
                            end
                        end
                        S_DRAIN: begin
                            if (is_last(cnt_q, DRAIN)) begin
                                state_d = S_OFIFO;
                                cnt_d   = '0;
                            end else begin
                                cnt_d = cnt_q + 1'b1;
                            end
                        end
                        S_OFIFO: begin
                            if (is_last(cnt_q, N_Q)) begin
                                state_d = S_NORM;
                                cnt_d   = '0;
                                sub_d   = '0;
                            end else begin
                                cnt_d = cnt_q + 1'b1;
                            end
                        end
                        S_NORM: begin
                            if (sub_q == 2'd3) begin
                                sub_d = '0;
                                if (is_last(cnt_q, N_Q)) begin
                                    state_d = S_DONE;
                                end else begin
                                    cnt_d = cnt_q + 1'b1;
                                end
                            end else begin
                                sub_d = sub_q + 1'b1;
                            end
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
        endcase
    end

    // Word for the position being entered; a held cycle shows all-zero.
    always_comb begin
        word_d = '0;
        unique case (state_d)
            S_QLOAD: begin
                word_d[B_QK_WR] = 1'b1;
                word_d[3:0]     = cnt_d[3:0];
            end
            S_KLOAD: begin
                word_d[B_LOAD]  = 1'b1;
                word_d[B_QK_RD] = 1'b1;
                word_d[3:0]     = 4'(N_Q) + cnt_d[3:0];
            end
            S_EXEC: begin
                word_d[B_EXECUTE] = 1'b1;
                word_d[B_QK_RD]   = 1'b1;
                word_d[3:0]       = cnt_d[3:0];
            end
            S_OFIFO: begin
                word_d[B_OFIFO_RD] = 1'b1;
                word_d[B_PMEM_WR]  = 1'b1;
                word_d[7:4]        = cnt_d[3:0];
            end
            S_NORM: begin
                unique case (sub_d)
                    2'd0: begin
                        word_d[B_PMEM_RD] = 1'b1;
                        word_d[7:4]       = cnt_d[3:0];
                    end
                    2'd1: begin
                        word_d[B_ACC] = 1'b1;
                        word_d[B_SUM] = 1'b1;
                    end
                    // Both peer FIFO reads must land in the same cycle.
                    2'd2: word_d[B_EXT_RD] = (en_d == 2'b11);
                    default: begin
                        word_d[B_DIV]     = 1'b1;
                        word_d[B_PMEM_WR] = 1'b1;
                        word_d[7:4]       = cnt_d[3:0];
                    end
                endcase
            end
            default: word_d = '0;
        endcase
        if (frozen_d) begin
            word_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sub_q   <= '0;
            en_q    <= '0;
            inst1_q <= '0;
            inst2_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            phase_q <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sub_q   <= sub_d;
            en_q    <= en_d;
            inst1_q <= en_d[0] ? word_d : '0;
            inst2_q <= en_d[1] ? word_d : '0;
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_d == S_DONE);
            phase_q <= state_d;
        end
    end

    assign inst1_o = inst1_q;
    assign inst2_o = inst2_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign phase_o = phase_q;

endmodule
`default_nettype wire

// File: tb/tb_dual_core_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dual_core_seq
//  Description : Randomized bench for dual_core_seq against a word-list model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dual_core_seq;

    localparam int COL   = 8;
    localparam int N_Q   = 8;
    localparam int DRAIN = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  core_en;
    logic        hold;
    logic [18:0] inst1, inst2;
    logic        busy, done;
    logic [2:0]  phase;

    int n_vec = 0;
    int n_err = 0;

    logic [18:0] e1[$];
    logic [18:0] e2[$];
    logic [2:0]  ep[$];

    dual_core_seq #(.COL(COL), .N_Q(N_Q), .DRAIN(DRAIN)) u_dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .start_i   (start),
        .core_en_i (core_en),
        .hold_i    (hold),
        .inst1_o   (inst1),
        .inst2_o   (inst2),
        .busy_o    (busy),
        .done_o    (done),
        .phase_o   (phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push_w(input logic [1:0] en, input logic [18:0] w, input logic [2:0] ph);
        e1.push_back(en[0] ? w : 19'h0);
        e2.push_back(en[1] ? w : 19'h0);
        ep.push_back(ph);
    endtask

    // Expected word list for one pass, straight from the field rules.
    task automatic build_model(input logic [1:0] en);
        e1.delete(); e2.delete(); ep.delete();
        for (int i = 0; i < N_Q; i++)   push_w(en, 19'h01000 | 19'(i), 3'd1);
        for (int i = 0; i < COL; i++)   push_w(en, 19'h02100 | 19'(N_Q + i), 3'd2);
        for (int i = 0; i < N_Q; i++)   push_w(en, 19'h02200 | 19'(i), 3'd3);
        for (int i = 0; i < DRAIN; i++) push_w(en, 19'h0, 3'd4);
        for (int i = 0; i < N_Q; i++)   push_w(en, 19'h04400 | 19'(i * 16), 3'd5);
        for (int r = 0; r < N_Q; r++) begin
            push_w(en, 19'h00800 | 19'(r * 16), 3'd6);
            push_w(en, 19'h18000, 3'd6);
            push_w(en, (en == 2'b11) ? 19'h40000 : 19'h0, 3'd6);
            push_w(en, 19'h20400 | 19'(r * 16), 3'd6);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_phase"}, 32'(phase), 32'd0);
        chk({tag, "_busy"},  32'(busy),  32'd0);
        chk({tag, "_done"},  32'(done),  32'd0);
        chk({tag, "_inst1"}, 32'(inst1), 32'd0);
        chk({tag, "_inst2"}, 32'(inst2), 32'd0);
    endtask

    // hmode: 0 none, 1 random, 2 three cycles in KLOAD plus one on a NORM S2 slot
    task automatic run_pass(input logic [1:0] en, input int hmode, input int rst_word,
                            input bit repulse, input int exp_done, input int exp_s2);
        int idx, holds, cyc, s2cnt, n;
        bit held, aborted;
        build_model(en);
        n = e1.size();
        @(negedge clk);
        start = 1'b1; core_en = en; hold = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        start = 1'b0;
        if (en == 2'b00) begin
            chk("z_phase", 32'(phase), 32'd7);
            chk("z_done",  32'(done),  32'd1);
            chk("z_busy",  32'(busy),  32'd1);
            chk("z_inst",  32'(inst1 | inst2), 32'd0);
            @(negedge clk); hold = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            check_idle("z_idle");
            return;
        end
        idx = 0; holds = 0; cyc = 1; s2cnt = 0; held = 0; aborted = 0;
        for (int k = 0; k < 400 && idx < n; k++) begin
            chk("inst1", 32'(inst1), held ? 32'd0 : 32'(e1[idx]));
            chk("inst2", 32'(inst2), held ? 32'd0 : 32'(e2[idx]));
            chk("phase", 32'(phase), 32'(ep[idx]));
            chk("busy",  32'(busy),  32'd1);
            chk("done",  32'(done),  32'd0);
            if (en != 2'b11) chk("no_ext", 32'(inst1[18] | inst2[18]), 32'd0);
            if (!held && idx == 0)  chk("word1",  32'(inst1 | inst2), 32'h01000);
            if (!held && idx == 8)  chk("word9",  32'(inst1 | inst2), 32'h02108);
            if (!held && idx == 16) chk("word17", 32'(inst1 | inst2), 32'h02200);
            if (inst1 == 19'h40000 && inst2 == 19'h40000) s2cnt++;
            if (rst_word > 0 && !held && idx + 1 == rst_word) begin
                @(negedge clk); rst_n = 1'b0; hold = 1'b0;
                @(posedge clk); #1;
                check_idle("rst");
                @(negedge clk); rst_n = 1'b1;
                @(posedge clk); #1;
                check_idle("rst_after");
                aborted = 1;
                break;
            end
            @(negedge clk);
            case (hmode)
                1:       hold = ($urandom_range(0, 4) == 0);
                2:       hold = (idx == 11 && holds < 3) || (idx == 49 && holds == 3);
                default: hold = 1'b0;
            endcase
            start   = repulse && (ep[idx] == 3'd3);
            core_en = 2'($urandom);
            @(posedge clk); #1;
            if (hold) begin
                held = 1; holds++;
            end else begin
                held = 0; idx++;
            end
            cyc++;
        end
        if (aborted) return;
        chk("fin_phase", 32'(phase), 32'd7);
        chk("fin_done",  32'(done),  32'd1);
        chk("fin_busy",  32'(busy),  32'd1);
        chk("fin_inst",  32'(inst1 | inst2), 32'd0);
        if (exp_done > 0) chk("done_cycle", 32'(cyc), 32'(exp_done));
        if (exp_s2 >= 0)  chk("s2_count", 32'(s2cnt), 32'(exp_s2));
        @(negedge clk); hold = 1'($urandom_range(0, 1)); start = 1'b0;
        @(posedge clk); #1;
        check_idle("post");
        hold = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b1; core_en = 2'b11; hold = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        @(negedge clk); rst_n = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        check_idle("idle");

        run_pass(2'b11, 0, 0,  1'b0, 81, 8);
        run_pass(2'b01, 0, 0,  1'b0, 81, 0);
        run_pass(2'b11, 2, 0,  1'b0, 85, 8);
        run_pass(2'b11, 0, 40, 1'b0, 0,  -1);
        run_pass(2'b11, 0, 0,  1'b0, 81, 8);
        run_pass(2'b11, 0, 0,  1'b1, 81, 8);
        run_pass(2'b00, 0, 0,  1'b0, 0,  -1);
        run_pass(2'b10, 1, 0,  1'b0, 0,  0);
        for (int p = 0; p < 4; p++) begin
            run_pass(2'($urandom), 1, 0, 1'($urandom), 0, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
